store_fsm: RTL
==============

STORE_FSM -- requirements
Module: store_fsm

Interface
REQ-001 Parameter WORD_W, default 32: memory address width in bits.
REQ-002 Parameter BITS_PER_ROW, default 64: scratchpad row width in bits; BYTES_PER_ROW = BITS_PER_ROW/8.
REQ-003 Parameter MAT_S_W, default 3: matrix-select field width.
REQ-004 Parameter ROW_S_W, default 2: row-select field width; ROWS = 2**ROW_S_W.
REQ-005 CLK  in  1  single clock, all state updates on rising edge.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 instrFIFO_empty  in  1  store-instruction FIFO empty.
REQ-008 instrFIFO_rdata  in  2+MAT_S_W+ROW_S_W+WORD_W  head entry, fields {op[1:0], mat, row, addr} MSB to LSB.
REQ-009 instrFIFO_REN  out  1  pop head entry.
REQ-010 sStore  out  1  scratchpad row-read request.
REQ-011 sStore_mat  out  MAT_S_W  matrix being read.
REQ-012 sStore_row  out  ROW_S_W  row being read.
REQ-013 sStore_hit  in  1  read data valid this cycle.
REQ-014 sStore_data  in  BITS_PER_ROW  row read data.
REQ-015 storeFIFO_full  in  1  outbound memory-write FIFO full.
REQ-016 storeFIFO_WEN  out  1  push to outbound FIFO.
REQ-017 storeFIFO_wdata  out  WORD_W+BITS_PER_ROW  {addr, data}.
REQ-018 store_done  out  1  one-cycle pulse when a matrix store completes.
REQ-019 bad_op  out  1  one-cycle pulse when a non-store instruction is discarded.

Function
REQ-020 States IDLE, REQ, PUSH; outputs decoded from state plus registers mat_r, row_cnt, addr_r, data_r.
REQ-021 IDLE, instrFIFO_empty=0, op=2'b10: instrFIFO_REN=1 same cycle; latch mat_r=mat, addr_r=addr, row_cnt=0; next REQ.
REQ-022 IDLE, instrFIFO_empty=0, op!=2'b10: instrFIFO_REN=1 and bad_op=1 same cycle; remain IDLE.
REQ-023 IDLE, instrFIFO_empty=1: all outputs 0, remain IDLE.
REQ-024 Instruction row field is ignored; every store covers rows 0..ROWS-1 in ascending order.
REQ-025 REQ: sStore=1, sStore_mat=mat_r, sStore_row=row_cnt, held until sStore_hit; on hit latch data_r=sStore_data, next PUSH.
REQ-026 sStore_hit in any state other than REQ is ignored.
REQ-027 PUSH, storeFIFO_full=0: storeFIFO_WEN=1, storeFIFO_wdata={addr_r, data_r}; addr_r += BYTES_PER_ROW modulo 2**WORD_W.
REQ-028 In that push cycle: if row_cnt=ROWS-1, store_done=1 and next IDLE; else row_cnt+1, next REQ.
REQ-029 PUSH, storeFIFO_full=1: storeFIFO_WEN=0, all registers held, remain PUSH.
REQ-030 storeFIFO_WEN is never asserted while storeFIFO_full=1; instrFIFO_REN never while instrFIFO_empty=1.
REQ-031 Minimum latency: with hit and no backpressure, a matrix takes 1+2*ROWS cycles from pop to store_done; the next instruction may pop on the cycle after store_done.
REQ-032 storeFIFO_wdata and sStore_mat/sStore_row are 0 whenever their strobe is 0.

Reset
REQ-033 On nRST=0, asynchronously: state=IDLE, row_cnt=0, mat_r=0, addr_r=0, data_r=0, every output 0.
REQ-034 Reset mid-store abandons the instruction; no further pushes for it after release and no store_done.
REQ-035 First pop possible on the first rising edge with nRST=1.

Verification
REQ-036 Store mat=3, addr=0x1000, hit one cycle after each request -> 4 pushes at addrs 0x1000, 0x1008, 0x1010, 0x1018 with matching row data, sStore_row 0..3, one store_done.
REQ-037 storeFIFO_full=1 for 5 cycles during row 1 PUSH -> WEN stays 0, wdata held, push occurs on first not-full cycle, no data loss.
REQ-038 addr=0xFFFFFFF8 -> push addresses 0xFFFFFFF8, 0x00000000, 0x00000008, 0x00000010.
REQ-039 Head op=2'b01 -> popped with bad_op pulse, no sStore, no push; a following store entry runs normally.
REQ-040 nRST low during row 2 REQ -> all outputs 0 immediately; after release with empty FIFO, no WEN and no store_done.
REQ-041 Back-to-back store instructions, no stalls -> second pop in the cycle after first store_done, 8 pushes total.

Source files
------------

// File: rtl/store_fsm.sv
// Drains store instructions: reads every row of the selected scratchpad matrix and
// pushes {addr, row data} to the outbound memory-write FIFO, one row per request/push pair.
module store_fsm #(
  parameter int WORD_W       = 32,
  parameter int BITS_PER_ROW = 64,
  parameter int MAT_S_W      = 3,
  parameter int ROW_S_W      = 2
) (
  input  logic                                    CLK,
  input  logic                                    nRST,
  input  logic                                    instrFIFO_empty,
  input  logic [2+MAT_S_W+ROW_S_W+WORD_W-1:0]     instrFIFO_rdata,
  output logic                                    instrFIFO_REN,
  output logic                                    sStore,
  output logic [MAT_S_W-1:0]                      sStore_mat,
  output logic [ROW_S_W-1:0]                      sStore_row,
  input  logic                                    sStore_hit,
  input  logic [BITS_PER_ROW-1:0]                 sStore_data,
  input  logic                                    storeFIFO_full,
  output logic                                    storeFIFO_WEN,
  output logic [WORD_W+BITS_PER_ROW-1:0]          storeFIFO_wdata,
  output logic                                    store_done,
  output logic                                    bad_op
);

  localparam int BYTES_PER_ROW = BITS_PER_ROW / 8;
  localparam logic [ROW_S_W-1:0] LAST_ROW = {ROW_S_W{1'b1}};
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

  state_t                    state_q, state_d;
  logic [MAT_S_W-1:0]        mat_q, mat_d;
  logic [ROW_S_W-1:0]        row_q, row_d;
  logic [WORD_W-1:0]         addr_q, addr_d;
  logic [BITS_PER_ROW-1:0]   data_q, data_d;

  logic [1:0]                instr_op;
  logic [MAT_S_W-1:0]        instr_mat;
  logic [WORD_W-1:0]         instr_addr;
  logic [ROW_S_W-1:0]        unused_instr_row;

  // The row field is carried in the entry but a store always walks every row.
  assign instr_addr       = instrFIFO_rdata[WORD_W-1:0];
  assign unused_instr_row = instrFIFO_rdata[WORD_W +: ROW_S_W];
  assign instr_mat        = instrFIFO_rdata[WORD_W+ROW_S_W +: MAT_S_W];
  assign instr_op         = instrFIFO_rdata[WORD_W+ROW_S_W+MAT_S_W +: 2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mat_d           = mat_q;
    row_d           = row_q;
    addr_d          = addr_q;
    data_d          = data_q;
    instrFIFO_REN   = 1'b0;
    sStore          = 1'b0;
    sStore_mat      = '0;
    sStore_row      = '0;
    storeFIFO_WEN   = 1'b0;
    storeFIFO_wdata = '0;
    store_done      = 1'b0;
    bad_op          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!instrFIFO_empty) begin
          instrFIFO_REN = 1'b1;
          if (instr_op == OP_STORE) begin
            mat_d   = instr_mat;
            addr_d  = instr_addr;
            row_d   = '0;
            state_d = REQ;
          end else begin
            bad_op = 1'b1;
          end
        end
      end
      REQ: begin
        sStore     = 1'b1;
        sStore_mat = mat_q;
        sStore_row = row_q;
        if (sStore_hit) begin
          data_d  = sStore_data;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (!storeFIFO_full) begin
          storeFIFO_WEN   = 1'b1;
          storeFIFO_wdata = {addr_q, data_q};
          addr_d          = addr_q + WORD_W'(BYTES_PER_ROW);
          if (row_q == LAST_ROW) begin
            store_done = 1'b1;
            state_d    = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are combinational, so force them quiet while reset is held.
    if (!nRST) begin
      instrFIFO_REN   = 1'b0;
      sStore          = 1'b0;
      sStore_mat      = '0;
      sStore_row      = '0;
      storeFIFO_WEN   = 1'b0;
      storeFIFO_wdata = '0;
      store_done      = 1'b0;
      bad_op          = 1'b0;
    end
  end

endmodule
